// File: rtl/serial_rx_pkg.sv
// Shared types and constants for the serial receive path.
// Word length grows by one parity bit when PARITY_CHECK_EN is defined.
package serial_rx_pkg;

    localparam logic DIR_MSB_FIRST = 1'b1;
    localparam logic DIR_LSB_FIRST = 1'b0;

    typedef enum logic {IDLE, SHIFT} rx_state_t;

`ifdef PARITY_CHECK_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    function automatic int word_len(input int width);
        return width + PAR_BITS;
    endfunction

endpackage

// File: rtl/serial_rx_shifter.sv
// Shift register, bit counter and per-word direction latch for the serial receiver.
// Presents the completed word and its done strobe combinationally on the final-bit cycle.
module serial_rx_shifter
    import serial_rx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ser_in,
    input  logic             ser_valid,
    input  logic             dir,
    input  logic             sync,
    input  logic             first,
    output logic [WIDTH-1:0] word,
    output logic             done,
    output logic             par_err,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam int WORD_LEN = word_len(WIDTH);

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] base_reg;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] base_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             dir_q;
    logic             dir_eff;

    // SYNC discards the partial word before the same-cycle bit is applied
    always_comb begin
        base_reg = sync ? '0 : sreg;
        base_cnt = sync ? '0 : bit_cnt;
        dir_eff  = first ? dir : dir_q;
        if (dir_eff == DIR_MSB_FIRST)
            shifted = {base_reg[WIDTH-2:0], ser_in};
        else
            shifted = {ser_in, base_reg[WIDTH-1:1]};
        cnt_inc = base_cnt + CNT_W'(1);
        done    = ser_valid && (cnt_inc == CNT_W'(WORD_LEN));
        if (PAR_BITS != 0) begin
            word    = base_reg;
            par_err = (^base_reg) ^ ser_in;
        end else begin
            word    = shifted;
            par_err = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sreg    <= '0;
            bit_cnt <= '0;
            dir_q   <= DIR_LSB_FIRST;
        end else if (ser_valid) begin
            if (first)
                dir_q <= dir;
            if (done) begin
                sreg    <= '0;
                bit_cnt <= '0;
            end else begin
                sreg    <= shifted;
                bit_cnt <= cnt_inc;
            end
        end else if (sync) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end
    end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver with valid/ready output and sticky overrun flag.
// Define PARITY_CHECK_EN to append an even-parity bit to each word and report PAR_ERR.
//
//   state | meaning
//   IDLE  | no bits of the current word collected yet
//   SHIFT | word in progress, direction latched
module shift_deserializer
    import serial_rx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SER_IN,
    input  logic             SER_VALID,
    input  logic             DIR,
    input  logic             SYNC,
    output logic [WIDTH-1:0] DOUT,
    output logic             DOUT_VALID,
    input  logic             DOUT_READY,
    output logic             OVERRUN,
    input  logic             OVR_CLR,
    output logic             PAR_ERR,
    output logic [CNT_W-1:0] BIT_CNT
);

    rx_state_t        state;
    logic             first;
    logic             done;
    logic             perr;
    logic             drop;
    logic [WIDTH-1:0] word;

    assign first = (state == IDLE) || SYNC;
    assign drop  = done && DOUT_VALID && !DOUT_READY;

    serial_rx_shifter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shifter (
        .CLK       (CLK),
        .RST       (RST),
        .ser_in    (SER_IN),
        .ser_valid (SER_VALID),
        .dir       (DIR),
        .sync      (SYNC),
        .first     (first),
        .word      (word),
        .done      (done),
        .par_err   (perr),
        .bit_cnt   (BIT_CNT)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            DOUT       <= '0;
            DOUT_VALID <= 1'b0;
            OVERRUN    <= 1'b0;
            PAR_ERR    <= 1'b0;
        end else begin
            if (SER_VALID && !done)
                state <= SHIFT;
            else if (SYNC || done)
                state <= IDLE;

            if (done && !drop) begin
                DOUT       <= word;
                DOUT_VALID <= 1'b1;
                PAR_ERR    <= perr;
            end else if (DOUT_VALID && DOUT_READY) begin
                DOUT_VALID <= 1'b0;
            end

            // a fresh drop outranks a clear in the same cycle
            if (drop)
                OVERRUN <= 1'b1;
            else if (OVR_CLR)
                OVERRUN <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_deserializer.sv
// Scoreboard bench for shift_deserializer: randomized serial traffic against a bit-list reference model.
// Build with PARITY_CHECK_EN defined to exercise the parity variant.
module tb_shift_deserializer;

    localparam int W = 8;
`ifdef PARITY_CHECK_EN
    localparam int WL = W + 1;
`else
    localparam int WL = W;
`endif

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         SER_IN = 1'b0, SER_VALID = 1'b0, DIR = 1'b0, SYNC = 1'b0;
    logic         DOUT_READY = 1'b0, OVR_CLR = 1'b0;
    logic [W-1:0] DOUT;
    logic         DOUT_VALID, OVERRUN, PAR_ERR;
    logic [3:0]   BIT_CNT;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit           m_bits[$];
    bit           m_dir;
    bit           m_full;
    bit           m_ovr;
    logic [W:0]   exp_q[$];
    bit           mon_en = 1'b0;

    shift_deserializer #(.WIDTH(W), .CNT_W(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .SER_IN     (SER_IN),
        .SER_VALID  (SER_VALID),
        .DIR        (DIR),
        .SYNC       (SYNC),
        .DOUT       (DOUT),
        .DOUT_VALID (DOUT_VALID),
        .DOUT_READY (DOUT_READY),
        .OVERRUN    (OVERRUN),
        .OVR_CLR    (OVR_CLR),
        .PAR_ERR    (PAR_ERR),
        .BIT_CNT    (BIT_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // one clock edge of the specified behaviour, using the inputs the DUT just sampled
    task automatic model_edge(input bit v, b, d, s, r, oc);
        bit         done = 1'b0;
        bit         drop = 1'b0;
        logic [W:0] ent = '0;
        if (s) m_bits.delete();
        if (v) begin
            if (m_bits.size() == 0) m_dir = d;
            m_bits.push_back(b);
            if (m_bits.size() == WL) begin
                for (int i = 0; i < W; i++) begin
                    if (m_dir) ent[W-1-i] = m_bits[i];
                    else       ent[i]     = m_bits[i];
                end
`ifdef PARITY_CHECK_EN
                for (int i = 0; i < WL; i++) ent[W] = ent[W] ^ m_bits[i];
`endif
                done = 1'b1;
                m_bits.delete();
            end
        end
        if (done) begin
            if (!m_full || r) begin
                exp_q.push_back(ent);
                m_full = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (m_full && r) begin
            m_full = 1'b0;
        end
        if (drop)    m_ovr = 1'b1;
        else if (oc) m_ovr = 1'b0;
    endtask

    task automatic step(input bit v, b, d, s, r, oc);
        SER_VALID = v; SER_IN = b; DIR = d; SYNC = s; DOUT_READY = r; OVR_CLR = oc;
        @(posedge CLK);
        model_edge(v, b, d, s, r, oc);
        #1;
    endtask

    task automatic idle(input bit r, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, r, 1'b0);
    endtask

    // seq[7] goes first; in the parity build a correct even-parity bit follows
    task automatic send_seq(input logic [7:0] seq, input bit d, input bit r);
        for (int i = 7; i >= 0; i--) step(1'b1, seq[i], d, 1'b0, r, 1'b0);
`ifdef PARITY_CHECK_EN
        step(1'b1, ^seq, d, 1'b0, r, 1'b0);
`endif
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        SER_VALID = 1'b0; SYNC = 1'b0; OVR_CLR = 1'b0; DOUT_READY = 1'b0;
        RST = 1'b1;
        m_bits.delete(); exp_q.delete();
        m_full = 1'b0; m_ovr = 1'b0; m_dir = 1'b0;
        @(negedge CLK);
        chk("rst_dout", DOUT, 8'h00);
        chk("rst_valid", DOUT_VALID, 1'b0);
        chk("rst_ovr", OVERRUN, 1'b0);
        chk("rst_par", PAR_ERR, 1'b0);
        chk("rst_cnt", BIT_CNT, 4'd0);
        @(negedge CLK);
        RST = 1'b0;
        mon_en = 1'b1;
        @(posedge CLK); #1;
    endtask

    // monitor: compare flags every cycle, pop the scoreboard on each transfer
    always @(negedge CLK) begin
        if (mon_en && !RST) begin
            chk("valid", DOUT_VALID, m_full);
            chk("overrun", OVERRUN, m_ovr);
            chk("bit_cnt", BIT_CNT, m_bits.size());
            if (DOUT_VALID && DOUT_READY) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", DOUT, 32'hdead);
                end else begin
                    logic [W:0] e;
                    e = exp_q.pop_front();
                    chk("dout", DOUT, e[W-1:0]);
                    chk("par_err", PAR_ERR, e[W]);
                end
            end
        end
    end

    initial begin
        do_reset();

        // MSB-first word
        send_seq(8'h1B, 1'b1, 1'b1);
        @(negedge CLK);
        chk("t1_dout", DOUT, 8'h1B);
        chk("t1_valid", DOUT_VALID, 1'b1);
        idle(1'b1, 1);
        @(negedge CLK);
        chk("t1_valid_drop", DOUT_VALID, 1'b0);

        // LSB-first word, then DIR flipped mid-word
        send_seq(8'h1B, 1'b0, 1'b1);
        @(negedge CLK);
        chk("t2_dout", DOUT, 8'hD8);
        idle(1'b1, 2);
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] s;
            s = 8'h1B;
            step(1'b1, s[i], (i < 5) ? 1'b1 : 1'b0, 1'b0, 1'b1, 1'b0);
        end
`ifdef PARITY_CHECK_EN
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
`endif
        @(negedge CLK);
        chk("t2_dir_latched", DOUT, 8'hD8);
        idle(1'b1, 2);

        // overrun with consumer stalled, then clear
        send_seq(8'h1B, 1'b1, 1'b0);
        send_seq(8'hD8, 1'b1, 1'b0);
        @(negedge CLK);
        chk("t3_dout_kept", DOUT, 8'h1B);
        chk("t3_overrun", OVERRUN, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge CLK);
        chk("t3_ovr_clr", OVERRUN, 1'b0);
        idle(1'b1, 2);

        // reset mid-word
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        do_reset();
        chk("t4_cnt_after_rst", BIT_CNT, 4'd0);
        send_seq(8'hA6, 1'b1, 1'b1);
        @(negedge CLK);
        chk("t4_dout", DOUT, 8'hA6);
        idle(1'b1, 2);

        // SYNC with a qualified bit restarts the word on that bit
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, (i == 6), 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef PARITY_CHECK_EN
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
`endif
        @(negedge CLK);
        chk("t5_dout", DOUT, 8'h81);
        idle(1'b1, 2);

        // parity bit handling / ninth bit starts a new word
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] s;
            s = 8'h1B;
            step(1'b1, s[i], 1'b1, 1'b0, 1'b1, 1'b0);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge CLK);
`ifdef PARITY_CHECK_EN
        chk("t6_par_bad", PAR_ERR, 1'b1);
        idle(1'b1, 1);
        send_seq(8'h1B, 1'b1, 1'b1);
        @(negedge CLK);
        chk("t6_par_good", PAR_ERR, 1'b0);
`else
        chk("t6_par_tied", PAR_ERR, 1'b0);
        chk("t6_ninth_bit", BIT_CNT, 4'd1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
`endif
        do_reset();

        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            step(($urandom % 4) != 0, $urandom % 2, $urandom % 2,
                 ($urandom % 60) == 0, ($urandom % 3) != 0, ($urandom % 25) == 0);
        end

        // drain: every expected word must have been presented
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(1'b1, 4);
        chk("queue_drained", exp_q.size(), 0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
